cpu_control: RTL
================

// Module: cpu_control
// PURPOSE
// Multicycle sequencer for the CPU core. Owns the PC and instruction register, drives the shared system bus for
// instruction fetch and load/store, steps execute_mem through one instruction at a time and drives register file writeback.
// Sits between the system bus and execute_mem and the register file.
// PARAMETERS
// RESET_PC  32'h1000_0000  PC loaded on reset; first fetch address.
// PORTS
// clk                  in   1   clock; all state changes on rising edge
// reset                in   1   synchronous, active-high
// bus_ready            in   1   bus accepts a request this cycle
// bus_addr             out  30  word address (byte addr [31:2])
// bus_byte_enable      out  4   per-byte write/read enable
// bus_write_data       out  32  store data, lane-aligned
// bus_read_req         out  1   read request; held until accepted
// bus_write_req        out  1   write request; held until accepted
// bus_read_data        in   32  read response data
// bus_read_data_valid  in   1   read response strobe
// instruction          out  32  instruction register, to execute_mem
// pc                   out  32  current PC, to execute_mem
// rf_read_addr1/2      out  5   instruction[19:15] / [24:20], combinational from instruction register
// exec_enable          out  1   high only in EXECUTE
// exec_ready           in   1   execute_mem result valid
// exec_next_pc         in   32  next PC from execute_mem
// exec_rd_we           in   1   execute_mem requests rd write
// exec_rd_data         in   32  rd write data
// exec_read_issued     in   1   instruction is a load
// exec_write_req       in   1   instruction is a store
// exec_mem_addr        in   32  load/store byte address
// exec_write_data      in   32  store source (rs2 value)
// rf_write_enable      out  1   register file write strobe
// rf_write_addr        out  5   instruction[11:7]
// rf_write_data        out  32  writeback data
// instret              out  64  retired-instruction counter
// BEHAVIOUR
// Reset: state=FETCH, pc=RESET_PC, instruction=0, instret=0. All reqs/strobes 0 except bus_read_req (FETCH is entered).
// States: FETCH, FETCH_WAIT, DECODE, EXECUTE, LOAD_REQ, LOAD_WAIT, STORE.
// - FETCH: bus_read_req=1, bus_addr=pc[31:2], be=4'hF. Accepted when bus_ready=1 -> FETCH_WAIT.
// - FETCH_WAIT: on bus_read_data_valid, instruction<=bus_read_data -> DECODE.
// - DECODE: one cycle for synchronous register file read -> EXECUTE.
// - EXECUTE: exec_enable=1; wait while exec_ready=0. On exec_ready: pc<=exec_next_pc. Then:
//   - load -> LOAD_REQ.
//   - store -> STORE.
//   - else: rf write if exec_rd_we, then retire -> FETCH.
// - LOAD_REQ: bus_read_req=1, bus_addr=exec_mem_addr[31:2] (latched in EXECUTE), be=4'hF. On accept -> LOAD_WAIT.
// - LOAD_WAIT: on valid, rf write of the extracted value, then retire -> FETCH.
// - STORE: bus_write_req=1 until bus_ready, then retire -> FETCH. No write acknowledge.
// Retire: instret+=1 on every transition into FETCH except the one caused by reset. instret wraps at 2^64.
// Request/response rules:
// - A request is accepted in the cycle where req && bus_ready. Addr, data and be stay stable while req is held.
// - One outstanding read at most. Response latency is >=1 cycle after accept.
// - bus_read_data_valid outside FETCH_WAIT/LOAD_WAIT is ignored.
// rf_write_enable is a 1-cycle pulse, forced 0 when rd==0. Data is exec_rd_data, or load data in LOAD_WAIT.
// Load extraction uses funct3=instruction[14:12] and a=addr[1:0]:
// - LB/LBU: byte a, sign/zero extended.
// - LH/LHU: half a[1], a[0] ignored.
// - LW: full word, a ignored.
// Store lanes:
// - SB: data={4{d[7:0]}}, be=4'b0001<<a.
// - SH: data={2{d[15:0]}}, be=4'b0011<<{a[1],1'b0}.
// - SW: data=d, be=4'hF.
// - No misalignment traps.
// Reset mid-operation: any state -> FETCH next cycle; requests drop; pending rf write suppressed. Bus is reset in the same cycle.
// Minimum cycles/instr: ALU/branch 4, store 5, load 6 (zero-wait bus, latency 1).
// TESTING
// 1 Reset -> bus_read_req=1, bus_addr=30'h0400_0000, be=4'hF, pc=32'h1000_0000, instret=0.
// 2 Fetch addi x1,x0,5 (32'h00500093), bus_ready low 2 cycles, latency 3 -> req/addr held; one rf write x1=5; pc=+4; instret=1.
// 3 LB from 32'h2000_0003, read data 32'h80_112233 -> rf_write_data 32'hFFFF_FF80; same with LBU -> 32'h0000_0080.
// 4 SH to 32'h2000_0002, rs2=32'h1234_ABCD, bus_ready low 3 cycles -> bus_write_data 32'hABCD_ABCD, be 4'b1100, held 4 cycles.
// 5 exec_ready low 3 cycles on taken branch (exec_next_pc=pc-8) -> stays EXECUTE, no rf write, next fetch at pc-8.
// 6 Load to rd=x0 -> rf_write_enable never rises. reset in LOAD_WAIT, then late valid -> no rf write; FETCH at RESET_PC; instret=0.

Source files
------------

// File: rtl/cpu_control.sv
// Multicycle sequencer: owns PC, instruction register and retire counter, runs the
// fetch / decode / execute / load / store sequence on the shared system bus.
module cpu_control #(
    parameter logic [31:0] RESET_PC = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_ready,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    output logic        bus_read_req,
    output logic        bus_write_req,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_data_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [4:0]  rf_read_addr1,
    output logic [4:0]  rf_read_addr2,
    output logic        exec_enable,
    input  logic        exec_ready,
    input  logic [31:0] exec_next_pc,
    input  logic        exec_rd_we,
    input  logic [31:0] exec_rd_data,
    input  logic        exec_read_issued,
    input  logic        exec_write_req,
    input  logic [31:0] exec_mem_addr,
    input  logic [31:0] exec_write_data,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_STORE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] store_data_q, store_data_d;

    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        rf_we_raw;

    assign funct3 = instr_q[14:12];
    assign rd     = instr_q[11:7];

    function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract_load = {{24{b[7]}}, b};
            3'b001:  extract_load = {{16{h[15]}}, h};
            3'b100:  extract_load = {24'h0, b};
            3'b101:  extract_load = {16'h0, h};
            default: extract_load = w;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  store_lanes = {4{d[7:0]}};
            3'b001:  store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  store_be = 4'b0001 << a;
            3'b001:  store_be = 4'b0011 << {a[1], 1'b0};
            default: store_be = 4'hF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            instret_q    <= '0;
            mem_addr_q   <= '0;
            store_data_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instret_q    <= instret_d;
            mem_addr_q   <= mem_addr_d;
            store_data_q <= store_data_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instret_d    = instret_q;
        mem_addr_d   = mem_addr_q;
        store_data_d = store_data_q;
        case (state_q)
            S_FETCH:      if (bus_ready) state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: if (bus_read_data_valid) begin
                              instr_d = bus_read_data;
                              state_d = S_DECODE;
                          end
            S_DECODE:     state_d = S_EXECUTE;
            S_EXECUTE:    if (exec_ready) begin
                              pc_d         = exec_next_pc;
                              mem_addr_d   = exec_mem_addr;
                              store_data_d = exec_write_data;
                              if (exec_read_issued)    state_d = S_LOAD_REQ;
                              else if (exec_write_req) state_d = S_STORE;
                              else                     state_d = S_FETCH;
                          end
            S_LOAD_REQ:   if (bus_ready) state_d = S_LOAD_WAIT;
            S_LOAD_WAIT:  if (bus_read_data_valid) state_d = S_FETCH;
            S_STORE:      if (bus_ready) state_d = S_FETCH;
            default:      state_d = S_FETCH;
        endcase
        // Any entry into FETCH other than reset retires the current instruction.
        if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + 64'd1;
    end

    always_comb begin
        bus_read_req    = 1'b0;
        bus_write_req   = 1'b0;
        bus_addr        = '0;
        bus_byte_enable = '0;
        bus_write_data  = '0;
        exec_enable     = 1'b0;
        rf_we_raw       = 1'b0;
        rf_write_data   = '0;
        case (state_q)
            S_FETCH: begin
                bus_read_req    = 1'b1;
                bus_addr        = pc_q[31:2];
                bus_byte_enable = 4'hF;
            end
            S_EXECUTE: begin
                exec_enable   = 1'b1;
                rf_we_raw     = exec_ready && exec_rd_we && !exec_read_issued && !exec_write_req;
                rf_write_data = exec_rd_data;
            end
            S_LOAD_REQ: begin
                bus_read_req    = 1'b1;
                bus_addr        = mem_addr_q[31:2];
                bus_byte_enable = 4'hF;
            end
            S_LOAD_WAIT: begin
                rf_we_raw     = bus_read_data_valid;
                rf_write_data = extract_load(funct3, mem_addr_q[1:0], bus_read_data);
            end
            S_STORE: begin
                bus_write_req   = 1'b1;
                bus_addr        = mem_addr_q[31:2];
                bus_byte_enable = store_be(funct3, mem_addr_q[1:0]);
                bus_write_data  = store_lanes(funct3, store_data_q);
            end
            default: ;
        endcase
    end

    // Writes to x0 and writes coinciding with reset are dropped.
    assign rf_write_enable = rf_we_raw && (rd != 5'd0) && !reset;
    assign rf_write_addr   = rd;
    assign rf_read_addr1   = instr_q[19:15];
    assign rf_read_addr2   = instr_q[24:20];
    assign instruction     = instr_q;
    assign pc              = pc_q;
    assign instret         = instret_q;

endmodule
